data_mem_bridge: RTL and testbench



---
 rtl/data_mem_bridge_pkg.sv | 24 ++
 rtl/data_mem_bridge.sv | 122 ++++++++++++
 tb/tb_data_mem_bridge.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_bridge_pkg.sv
// rtl/data_mem_bridge_pkg.sv - state encoding and bus type constants for the data memory bridge
package data_mem_bridge_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_WAIT = 3'd3;
  localparam logic [2:0] S_WR_REQ  = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;
  localparam logic [2:0] S_DISCARD = 3'd6;

  localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
  localparam logic [2:0] RD_TYPE_HALF = 3'b001;
  localparam logic [2:0] RD_TYPE_WORD = 3'b010;
  localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
  localparam logic [2:0] WR_TYPE_HALF = 3'b001;
  localparam logic [2:0] WR_TYPE_WORD = 3'b010;

  // Single-beat bus types map directly from the access size.
  function automatic logic [2:0] bus_type(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - cache-less data port: memory-stage load/store to single-beat
// memory request/return bus, one transaction outstanding.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  input  logic [31:0] data_paddr,
  input  logic        data_uncache_en,
  input  logic        tlb_excp_cancel_req,
  input  logic        pipe_flush,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        dcache_miss,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data,
  output logic        wr_req,
  output logic [2:0]  wr_type,
  output logic [31:0] wr_addr,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_data,
  input  logic        wr_rdy,
  output logic        mem_uc
);

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] paddr_q;
  logic        uc_q;
  logic        accept;
  logic        ret_done;

  assign data_addr_ok = ((state == S_IDLE) || (state == S_RESP)) && !pipe_flush && !reset;
  assign accept       = data_req && data_addr_ok;
  assign ret_done     = ret_valid && ret_last;

  assign rd_type  = bus_type(size_q);
  assign rd_addr  = paddr_q;
  assign wr_type  = bus_type(size_q);
  assign wr_addr  = paddr_q;
  assign wr_wstrb = wstrb_q;
  assign wr_data  = wdata_q;
  assign mem_uc   = uc_q && (rd_req || wr_req || (state == S_RD_WAIT));

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_RESP: state_n = accept ? S_LOOKUP : S_IDLE;
      S_LOOKUP: begin
        if (tlb_excp_cancel_req || pipe_flush) state_n = S_IDLE;
        else if (wr_q)                         state_n = S_WR_REQ;
        else                                   state_n = S_RD_REQ;
      end
      // A flush coinciding with rd_rdy is too late to withdraw; the return must be drained.
      S_RD_REQ: begin
        if (rd_rdy)          state_n = pipe_flush ? S_DISCARD : S_RD_WAIT;
        else if (pipe_flush) state_n = S_IDLE;
      end
      S_RD_WAIT: begin
        if (ret_done)        state_n = pipe_flush ? S_IDLE : S_RESP;
        else if (pipe_flush) state_n = S_DISCARD;
      end
      S_WR_REQ: begin
        if (wr_rdy)          state_n = S_RESP;
        else if (pipe_flush) state_n = S_IDLE;
      end
      S_DISCARD: if (ret_done) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rd_req       <= 1'b0;
      wr_req       <= 1'b0;
      data_data_ok <= 1'b0;
      dcache_miss  <= 1'b0;
      data_rdata   <= '0;
      wr_q         <= 1'b0;
      size_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      paddr_q      <= '0;
      uc_q         <= 1'b0;
    end else begin
      state        <= state_n;
      rd_req       <= (state_n == S_RD_REQ);
      wr_req       <= (state_n == S_WR_REQ);
      data_data_ok <= (state_n == S_RESP);
      dcache_miss  <= (state_n == S_RESP) && !uc_q;
      if (accept) begin
        wr_q    <= data_wr;
        size_q  <= data_size;
        wstrb_q <= data_wstrb;
        wdata_q <= data_wdata;
      end
      if (state == S_LOOKUP) begin
        paddr_q <= data_paddr;
        uc_q    <= data_uncache_en;
      end
      if ((state == S_RD_WAIT) && ret_done) data_rdata <= ret_data;
      else if ((state == S_WR_REQ) && wr_rdy) data_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - directed self-checking bench for data_mem_bridge
module tb_data_mem_bridge;

  logic        clk;
  logic        reset;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_paddr;
  logic        data_uncache_en;
  logic        tlb_excp_cancel_req;
  logic        pipe_flush;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        dcache_miss;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  logic        wr_req;
  logic [2:0]  wr_type;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_data;
  logic        wr_rdy;
  logic        mem_uc;

  int total = 0;
  int bad   = 0;
  int ok_cnt = 0;
  int wr_cnt = 0;
  int overlap_cnt = 0;
  int base_ok;
  int base_wr;

  data_mem_bridge dut (
    .clk(clk), .reset(reset), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_paddr(data_paddr), .data_uncache_en(data_uncache_en),
    .tlb_excp_cancel_req(tlb_excp_cancel_req), .pipe_flush(pipe_flush),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .dcache_miss(dcache_miss),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy), .mem_uc(mem_uc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: sampled mid-cycle, so a handshake seen here completes at the next edge.
  always @(negedge clk) begin
    if (data_data_ok) ok_cnt++;
    if (wr_req && wr_rdy) wr_cnt++;
    if (rd_req && wr_req) overlap_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_wdata = 0;
    data_paddr = 0; data_uncache_en = 0; tlb_excp_cancel_req = 0; pipe_flush = 0;
    rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0; wr_rdy = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1; data_req = 1; ret_valid = 1; ret_last = 1; ret_data = 32'h1111_2222;
    tick(); tick();
    smp();
    total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL rst_addr_ok_in_reset got=%b exp=0", data_addr_ok); end
    tick();
    reset = 0; idle_inputs();
    smp();
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL rst_rd_req got=%b exp=0", rd_req); end
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL rst_wr_req got=%b exp=0", wr_req); end
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_ok got=%b exp=0", data_data_ok); end
    total++; if (dcache_miss !== 1'b0) begin bad++; $display("FAIL rst_dcache_miss got=%b exp=0", dcache_miss); end
    total++; if (mem_uc !== 1'b0) begin bad++; $display("FAIL rst_mem_uc got=%b exp=0", mem_uc); end
    total++; if (data_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", data_rdata); end
    total++; if (rd_addr !== 32'h0) begin bad++; $display("FAIL rst_rd_addr got=%h exp=0", rd_addr); end
    total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL rst_addr_ok_after got=%b exp=1", data_addr_ok); end
    tick();
  endtask

  task automatic test_load_cached;
    base_ok = ok_cnt;
    data_req = 1; data_wr = 0; data_size = 2'd2;
    smp();
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL ld_accept got=%b exp=1", data_addr_ok); end
    tick();
    data_req = 0; data_paddr = 32'h1c00_0104; data_uncache_en = 0;
    smp();
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL ld_lookup_rd_req got=%b exp=0", rd_req); end
    tick();
    data_paddr = 32'h0; rd_rdy = 1;
    smp();
    total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL ld_rd_req got=%b exp=1", rd_req); end
    total++; if (rd_addr !== 32'h1c00_0104) begin bad++; $display("FAIL ld_rd_addr got=%h exp=1c000104", rd_addr); end
    total++; if (rd_type !== 3'b010) begin bad++; $display("FAIL ld_rd_type got=%b exp=010", rd_type); end
    total++; if (mem_uc !== 1'b0) begin bad++; $display("FAIL ld_mem_uc got=%b exp=0", mem_uc); end
    total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL ld_busy_addr_ok got=%b exp=0", data_addr_ok); end
    tick();
    rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'hdead_beef;
    smp();
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL ld_rd_req_drop got=%b exp=0", rd_req); end
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL ld_early_ok got=%b exp=0", data_data_ok); end
    tick();
    ret_valid = 0; ret_last = 0; ret_data = 0;
    smp();
    total++; if (data_data_ok !== 1'b1) begin bad++; $display("FAIL ld_data_ok_t4 got=%b exp=1", data_data_ok); end
    total++; if (data_rdata !== 32'hdead_beef) begin bad++; $display("FAIL ld_rdata got=%h exp=deadbeef", data_rdata); end
    total++; if (dcache_miss !== 1'b1) begin bad++; $display("FAIL ld_dcache_miss got=%b exp=1", dcache_miss); end
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL ld_resp_addr_ok got=%b exp=1", data_addr_ok); end
    tick();
    smp();
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL ld_ok_one_cycle got=%b exp=0", data_data_ok); end
    total++; if (ok_cnt - base_ok !== 1) begin bad++; $display("FAIL ld_pulse_count got=%0d exp=1", ok_cnt - base_ok); end
    tick();
  endtask

  task automatic test_store_uncached;
    base_ok = ok_cnt; base_wr = wr_cnt;
    data_req = 1; data_wr = 1; data_size = 2'd0; data_wstrb = 4'b0100; data_wdata = 32'h00aa_0000;
    tick();
    idle_inputs(); data_paddr = 32'h1fe0_01e2; data_uncache_en = 1;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      wr_rdy = (i == 3);
      smp();
      total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL st_wr_req_hold%0d got=%b exp=1", i, wr_req); end
      total++; if (mem_uc !== 1'b1) begin bad++; $display("FAIL st_mem_uc%0d got=%b exp=1", i, mem_uc); end
      total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL st_early_ok%0d got=%b exp=0", i, data_data_ok); end
      tick();
    end
    wr_rdy = 0;
    total++; if (wr_addr !== 32'h1fe0_01e2) begin bad++; $display("FAIL st_wr_addr got=%h exp=1fe001e2", wr_addr); end
    total++; if (wr_wstrb !== 4'b0100) begin bad++; $display("FAIL st_wr_wstrb got=%b exp=0100", wr_wstrb); end
    total++; if (wr_data !== 32'h00aa_0000) begin bad++; $display("FAIL st_wr_data got=%h exp=00aa0000", wr_data); end
    total++; if (wr_type !== 3'b000) begin bad++; $display("FAIL st_wr_type got=%b exp=000", wr_type); end
    smp();
    total++; if (data_data_ok !== 1'b1) begin bad++; $display("FAIL st_data_ok got=%b exp=1", data_data_ok); end
    total++; if (dcache_miss !== 1'b0) begin bad++; $display("FAIL st_dcache_miss got=%b exp=0", dcache_miss); end
    total++; if (data_rdata !== 32'h0) begin bad++; $display("FAIL st_rdata got=%h exp=0", data_rdata); end
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL st_wr_req_drop got=%b exp=0", wr_req); end
    total++; if (mem_uc !== 1'b0) begin bad++; $display("FAIL st_mem_uc_resp got=%b exp=0", mem_uc); end
    total++; if (wr_cnt - base_wr !== 1) begin bad++; $display("FAIL st_write_count got=%0d exp=1", wr_cnt - base_wr); end
    tick();
  endtask

  task automatic test_tlb_cancel;
    base_ok = ok_cnt; base_wr = wr_cnt;
    data_req = 1; data_wr = 0; data_size = 2'd2;
    tick();
    idle_inputs(); data_paddr = 32'h0000_8000; tlb_excp_cancel_req = 1;
    tick();
    idle_inputs();
    smp();
    total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL tlb_rd_req got=%b exp=0", rd_req); end
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL tlb_wr_req got=%b exp=0", wr_req); end
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL tlb_addr_ok got=%b exp=1", data_addr_ok); end
    tick(); tick();
    smp();
    total++; if (ok_cnt - base_ok !== 0) begin bad++; $display("FAIL tlb_no_ok got=%0d exp=0", ok_cnt - base_ok); end
    tick();
  endtask

  task automatic test_flush_rd_wait;
    base_ok = ok_cnt;
    data_req = 1; data_wr = 0; data_size = 2'd1;
    tick();
    idle_inputs(); data_paddr = 32'h0000_0042;
    tick();
    idle_inputs(); rd_rdy = 1;
    smp();
    total++; if (rd_type !== 3'b001) begin bad++; $display("FAIL fl_rd_type got=%b exp=001", rd_type); end
    tick();
    rd_rdy = 0; pipe_flush = 1;
    tick();
    pipe_flush = 0;
    for (int i = 0; i < 5; i++) begin
      ret_valid = (i == 4); ret_last = (i == 4); ret_data = 32'hbad0_0bad;
      smp();
      total++; if (data_addr_ok !== 1'b0) begin bad++; $display("FAIL fl_discard_addr_ok%0d got=%b exp=0", i, data_addr_ok); end
      tick();
    end
    idle_inputs();
    smp();
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL fl_after_addr_ok got=%b exp=1", data_addr_ok); end
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL fl_data_ok got=%b exp=0", data_data_ok); end
    tick();
    smp();
    total++; if (ok_cnt - base_ok !== 0) begin bad++; $display("FAIL fl_no_ok got=%0d exp=0", ok_cnt - base_ok); end
    tick();
  endtask

  task automatic test_flush_wr_req;
    base_ok = ok_cnt; base_wr = wr_cnt;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hf; data_wdata = 32'h5555_aaaa;
    tick();
    idle_inputs(); data_paddr = 32'h0000_1000;
    tick();
    idle_inputs(); pipe_flush = 1;
    smp();
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL fw_wr_req got=%b exp=1", wr_req); end
    tick();
    pipe_flush = 0;
    smp();
    total++; if (wr_req !== 1'b0) begin bad++; $display("FAIL fw_wr_req_drop got=%b exp=0", wr_req); end
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL fw_addr_ok got=%b exp=1", data_addr_ok); end
    wr_rdy = 1;
    tick(); tick();
    wr_rdy = 0;
    smp();
    total++; if (wr_cnt - base_wr !== 0) begin bad++; $display("FAIL fw_no_write got=%0d exp=0", wr_cnt - base_wr); end
    total++; if (ok_cnt - base_ok !== 0) begin bad++; $display("FAIL fw_no_ok got=%0d exp=0", ok_cnt - base_ok); end
    tick();
  endtask

  task automatic test_back_to_back;
    base_ok = ok_cnt;
    overlap_cnt = 0;
    data_req = 1; data_wr = 0; data_size = 2'd2;
    tick();
    idle_inputs(); data_paddr = 32'h1c00_0200;
    tick();
    idle_inputs(); rd_rdy = 1;
    tick();
    rd_rdy = 0; ret_valid = 1; ret_last = 1; ret_data = 32'h0bad_f00d;
    tick();
    idle_inputs();
    data_req = 1; data_wr = 1; data_size = 2'd2; data_wstrb = 4'hf; data_wdata = 32'h1234_5678;
    smp();
    total++; if (data_data_ok !== 1'b1) begin bad++; $display("FAIL b2b_ld_ok_t4 got=%b exp=1", data_data_ok); end
    total++; if (data_rdata !== 32'h0bad_f00d) begin bad++; $display("FAIL b2b_ld_rdata got=%h exp=0badf00d", data_rdata); end
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL b2b_accept_in_resp got=%b exp=1", data_addr_ok); end
    tick();
    idle_inputs(); data_paddr = 32'h1c00_0300;
    smp();
    total++; if (data_data_ok !== 1'b0) begin bad++; $display("FAIL b2b_bubble got=%b exp=0", data_data_ok); end
    tick();
    idle_inputs(); wr_rdy = 1;
    smp();
    total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL b2b_wr_req got=%b exp=1", wr_req); end
    total++; if (wr_addr !== 32'h1c00_0300) begin bad++; $display("FAIL b2b_wr_addr got=%h exp=1c000300", wr_addr); end
    tick();
    wr_rdy = 0;
    smp();
    total++; if (data_data_ok !== 1'b1) begin bad++; $display("FAIL b2b_st_ok_t7 got=%b exp=1", data_data_ok); end
    total++; if (data_rdata !== 32'h0) begin bad++; $display("FAIL b2b_st_rdata got=%h exp=0", data_rdata); end
    total++; if (dcache_miss !== 1'b1) begin bad++; $display("FAIL b2b_st_miss got=%b exp=1", dcache_miss); end
    tick();
    smp();
    total++; if (ok_cnt - base_ok !== 2) begin bad++; $display("FAIL b2b_pulse_count got=%0d exp=2", ok_cnt - base_ok); end
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL b2b_overlap got=%0d exp=0", overlap_cnt); end
    tick();
  endtask

  task automatic test_reset_mid;
    base_ok = ok_cnt;
    data_req = 1; data_wr = 0; data_size = 2'd2;
    tick();
    idle_inputs(); data_paddr = 32'h0000_0400; data_uncache_en = 1;
    tick();
    idle_inputs(); rd_rdy = 1;
    tick();
    idle_inputs(); reset = 1;
    tick();
    reset = 0;
    smp();
    total++; if (mem_uc !== 1'b0) begin bad++; $display("FAIL rm_mem_uc got=%b exp=0", mem_uc); end
    total++; if (data_addr_ok !== 1'b1) begin bad++; $display("FAIL rm_addr_ok got=%b exp=1", data_addr_ok); end
    ret_valid = 1; ret_last = 1; ret_data = 32'hcafe_cafe;
    tick();
    idle_inputs();
    tick();
    smp();
    total++; if (ok_cnt - base_ok !== 0) begin bad++; $display("FAIL rm_no_ok got=%0d exp=0", ok_cnt - base_ok); end
    total++; if (data_rdata !== 32'h0) begin bad++; $display("FAIL rm_rdata got=%h exp=0", data_rdata); end
    tick();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_load_cached();
    test_store_uncached();
    test_tlb_cancel();
    test_flush_rd_wait();
    test_flush_wr_req();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
